ram_stream_reader: RTL and testbench

Read initiator for one port of a synchronous-read single/dual-port RAM with 1-cycle read latency, address registered on clk and data valid the next cycle.
- Accepts a block-read command (word address, word count) over a req/ack handshake.
- Issues sequential reads and returns the words as a valid/ready stream with a last flag.
- Used for the port-1 side of instruction/data memories: dump-out, DMA source, checksum units.
- Never writes memory.

---
 rtl/ram_stream_pkg.sv | 12 +
 rtl/ram_rd_fifo.sv | 40 ++++
 rtl/ram_stream_reader.sv | 107 ++++++++++
 tb/tb_ram_stream_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM block-read stream initiator.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_rd_fifo.sv
// Two-entry registered FIFO holding returned read words tagged with the last flag.
module ram_rd_fifo
    import ram_stream_pkg::*;
#(
    parameter int width = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_dat,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             valid,
    output logic [1:0]       count
);

    logic [width-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != 2'd0);

endmodule

// File: rtl/ram_stream_reader.sv
// Block-read initiator: turns (address, count) commands into sequential RAM reads
// and returns the words as a valid/ready stream with a last flag.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int dat_width = 32,
    parameter int adr_width = 32,
    parameter int len_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_req_i,
    output logic                 cmd_ack_o,
    input  logic [adr_width-1:0] cmd_adr_i,
    input  logic [len_width-1:0] cmd_len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [adr_width-1:0] ram_adr_o,
    output logic                 ram_we_o,
    output logic [dat_width-1:0] ram_dat_o,
    input  logic [dat_width-1:0] ram_dat_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [dat_width-1:0] out_dat_o,
    output logic                 out_last_o
);

    state_t               state, state_nxt;
    logic [adr_width-1:0] cur_adr;
    logic [len_width-1:0] remaining;
    logic                 inflight;
    logic                 inflight_last;
    logic [1:0]           fifo_count;
    logic                 fifo_valid;
    logic [dat_width:0]   head;
    logic                 cmd_fire, pop, last_fire, issue, last_issue;

    assign cmd_fire   = cmd_req_i & cmd_ack_o;
    assign pop        = out_valid_o & out_ready_i;
    assign last_fire  = pop & out_last_o;
    assign last_issue = (remaining == len_width'(1));
    // Slots already claimed: buffered words plus the word on ram_dat_i, less this cycle's pop.
    assign issue = (state == ST_RUN) && (remaining != '0) &&
                   (({1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop}) < 3'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd_fire && cmd_len_i != '0) state_nxt = ST_RUN;
            ST_RUN:   if (issue && last_issue)         state_nxt = ST_DRAIN;
            ST_DRAIN: if (last_fire)                   state_nxt = ST_IDLE;
            default:                                   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ack_o = (state == ST_IDLE);
        busy_o    = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_adr       <= '0;
            remaining     <= '0;
            ram_adr_o     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            inflight <= issue;
            done_o   <= (cmd_fire && cmd_len_i == '0) || (state == ST_DRAIN && last_fire);
            if (cmd_fire) begin
                cur_adr   <= cmd_adr_i;
                remaining <= cmd_len_i;
            end
            if (issue) begin
                ram_adr_o     <= cur_adr;
                cur_adr       <= cur_adr + adr_width'(1);
                remaining     <= remaining - len_width'(1);
                inflight_last <= last_issue;
            end
        end
    end

    ram_rd_fifo #(.width(dat_width + 1)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_dat ({inflight_last, ram_dat_i}),
        .pop      (pop),
        .head     (head),
        .valid    (fifo_valid),
        .count    (fifo_count)
    );

    assign out_valid_o = fifo_valid;
    assign out_dat_o   = head[dat_width-1:0];
    assign out_last_o  = fifo_valid & head[dat_width];
    assign ram_we_o    = 1'b0;
    assign ram_dat_o   = '0;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench: a queue-based scoreboard of expected words per accepted command,
// plus directed scenarios with literal cycle-by-cycle expectations.
module tb_ram_stream_reader;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_req, cmd_ack, busy, done;
    logic [AW-1:0] cmd_adr, ram_adr;
    logic [LW-1:0] cmd_len;
    logic          ram_we, out_valid, out_ready, out_last;
    logic [DW-1:0] ram_wdat, ram_dat, out_dat;

    logic          w_cmd_req, w_cmd_ack, w_busy, w_done, w_ram_we;
    logic          w_out_valid, w_out_ready, w_out_last;
    logic [3:0]    w_cmd_adr, w_ram_adr;
    logic [LW-1:0] w_cmd_len;
    logic [DW-1:0] w_ram_wdat, w_ram_dat, w_out_dat;

    logic [DW-1:0] mem [0:255];

    always #5 clk = ~clk;

    // RAM model: ram_adr_o is the registered read address; its word appears on the data bus.
    assign ram_dat   = mem[ram_adr[7:0]];
    assign w_ram_dat = mem[{4'h0, w_ram_adr}];

    ram_stream_reader #(.dat_width(DW), .adr_width(AW), .len_width(LW)) u_dut (
        .clk(clk), .rst(rst), .cmd_req_i(cmd_req), .cmd_ack_o(cmd_ack),
        .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .busy_o(busy), .done_o(done),
        .ram_adr_o(ram_adr), .ram_we_o(ram_we), .ram_dat_o(ram_wdat), .ram_dat_i(ram_dat),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_dat_o(out_dat),
        .out_last_o(out_last)
    );

    ram_stream_reader #(.dat_width(DW), .adr_width(4), .len_width(LW)) u_wrap (
        .clk(clk), .rst(rst), .cmd_req_i(w_cmd_req), .cmd_ack_o(w_cmd_ack),
        .cmd_adr_i(w_cmd_adr), .cmd_len_i(w_cmd_len), .busy_o(w_busy), .done_o(w_done),
        .ram_adr_o(w_ram_adr), .ram_we_o(w_ram_we), .ram_dat_o(w_ram_wdat), .ram_dat_i(w_ram_dat),
        .out_valid_o(w_out_valid), .out_ready_i(w_out_ready), .out_dat_o(w_out_dat),
        .out_last_o(w_out_last)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Scoreboard: an accepted command of len words expects mem[adr..adr+len-1], last on the final one.
    logic [DW:0]   exp_q [$];
    logic          exp_busy = 1'b0, exp_done = 1'b0, chk_en = 1'b0, stall_prev = 1'b0;
    logic          last_prev = 1'b0, nb, nd;
    logic [DW-1:0] dat_prev = '0;
    logic [AW-1:0] a;
    int            words_rx = 0, done_cnt = 0;

    always @(negedge clk) begin : compare
        if (chk_en) begin
            check("done", done, exp_done);
            check("busy", busy, exp_busy);
            check("cmd_ack", cmd_ack, !exp_busy);
            check("ram_write_side", {ram_we, ram_wdat}, '0);
            if (done) done_cnt++;
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_word", {out_last, out_dat}, {last_prev, dat_prev});
            end
            nb = exp_busy;
            nd = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) check("spurious_word", out_valid, 0);
                else begin
                    check("out_word", {out_last, out_dat}, exp_q[0]);
                    if (out_ready) begin
                        if (exp_q[0][DW]) begin nb = 1'b0; nd = 1'b1; end
                        void'(exp_q.pop_front());
                        words_rx++;
                    end
                end
            end
            if (cmd_req && !exp_busy) begin
                if (cmd_len == '0) nd = 1'b1;
                else begin
                    nb = 1'b1;
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        a = cmd_adr + AW'(i);
                        exp_q.push_back({(i == int'(cmd_len) - 1), mem[a[7:0]]});
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            dat_prev   = out_dat;
            last_prev  = out_last;
            if (rst) begin
                exp_q.delete();
                nb = 1'b0;
                nd = 1'b0;
                stall_prev = 1'b0;
            end
            exp_busy = nb;
            exp_done = nd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [AW-1:0] adr, input logic [LW-1:0] len);
        cmd_req = 1'b1;
        cmd_adr = adr;
        cmd_len = len;
        step();
        cmd_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin step(); n++; end
        check({name, "_done_seen"}, done, 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $fatal(1);
    end

    initial begin : stim
        int w0, d0, n, nhs;
        logic [7:0]  lfsr;
        logic [15:0] wseq;

        for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 | i;
        for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + i;
        rst = 1'b1; cmd_req = 1'b0; cmd_adr = '0; cmd_len = '0; out_ready = 1'b1;
        w_cmd_req = 1'b0; w_cmd_adr = '0; w_cmd_len = '0; w_out_ready = 1'b1;
        step(); step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        step();

        // reset state
        check("rst_cmd_ack", cmd_ack, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_dat", out_dat, 0);
        check("rst_ram_adr", ram_adr, 0);

        // basic: adr 0x10, len 4; k counts cycles after the handshake cycle
        start_cmd(32'h10, 16'd4);
        for (int k = 1; k <= 7; k++) begin
            if (k >= 2 && k <= 5) check("t1_ram_adr", ram_adr, 32'h10 + k - 2);
            check("t1_valid", out_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) check("t1_dat", out_dat, 32'hA0 + k - 3);
            check("t1_last", out_last, (k == 6));
            check("t1_done", done, (k == 7));
            check("t1_busy", busy, (k <= 6));
            step();
        end

        // zero-length command
        check("t2_ack_before", cmd_ack, 1);
        start_cmd(32'h55, 16'd0);
        check("t2_done", done, 1);
        check("t2_ack", cmd_ack, 1);
        check("t2_valid", out_valid, 0);
        step();
        check("t2_done_after", done, 0);
        check("t2_ack_after", cmd_ack, 1);
        check("t2_valid_after", out_valid, 0);

        // backpressure: pseudo-random ready with a 10-cycle stall
        w0 = words_rx; d0 = done_cnt; n = 0; lfsr = 8'h5A;
        start_cmd(32'h40, 16'd8);
        while (!done && n < 300) begin
            if (n >= 5 && n < 15) out_ready = 1'b0;
            else begin
                out_ready = lfsr[0];
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
            step();
            n++;
        end
        out_ready = 1'b1;
        check("t3_done_seen", done, 1);
        check("t3_words", words_rx - w0, 8);
        step();
        check("t3_done_pulses", done_cnt - d0, 1);

        // address wrap on the 4-bit instance: 0xE, 0xF, 0x0, 0x1
        wseq = 16'hEF01;
        w_cmd_req = 1'b1; w_cmd_adr = 4'hE; w_cmd_len = 16'd4;
        check("t4_ack", w_cmd_ack, 1);
        step();
        w_cmd_req = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k >= 2 && k <= 5) check("t4_ram_adr", w_ram_adr, wseq[4*(5-k) +: 4]);
            check("t4_valid", w_out_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) check("t4_dat", w_out_dat, {28'hD000000, wseq[4*(6-k) +: 4]});
            check("t4_last", w_out_last, (k == 6));
            check("t4_done", w_done, (k == 7));
            check("t4_busy", w_busy, (k <= 6));
            check("t4_we", w_ram_we, 0);
            step();
        end
        check("t4_wdat", w_ram_wdat, 0);

        // command while busy is ignored
        w0 = words_rx; d0 = done_cnt;
        start_cmd(32'h30, 16'd6);
        step();
        cmd_req = 1'b1; cmd_adr = 32'h99; cmd_len = 16'd3;
        check("t6_ack_busy", cmd_ack, 0);
        step();
        cmd_req = 1'b0;
        check("t6_ack_busy2", cmd_ack, 0);
        wait_done("t6", 50);
        check("t6_words", words_rx - w0, 6);
        step();
        check("t6_done_pulses", done_cnt - d0, 1);

        // reset after the 3rd delivered word of len 8
        d0 = done_cnt; n = 0; nhs = 0;
        start_cmd(32'h80, 16'd8);
        while (nhs < 3 && n < 50) begin
            if (out_valid && out_ready) nhs++;
            step();
            n++;
        end
        check("t5_three_words", nhs, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        for (int k = 0; k < 5; k++) step();
        check("t5_no_done", done_cnt - d0, 0);
        w0 = words_rx;
        start_cmd(32'h20, 16'd2);
        wait_done("t5_after", 30);
        check("t5_after_words", words_rx - w0, 2);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
